memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 24 ++
 rtl/memory_access_lsu_align.sv | 73 +++++++
 rtl/memory_access.sv | 131 +++++++++++++
 3 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory-access stage: funct3 load/store widths,
// result-source select values and the access FSM state type.
package memory_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/memory_access_lsu_align.sv
// Combinational lane logic: store data replication and byte enables,
// load byte/halfword extraction with extension, and misalignment detection.
module lsu_align
  import memory_access_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (byte_off)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // A load and a store at once is treated like a misaligned access.
  always_comb begin
    wdata     = store_data;
    be        = 4'b1111;
    load_data = rdata;
    misalign  = 1'b0;
    if (is_load && is_store) begin
      misalign = 1'b1;
    end else if (is_store) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          be    = 4'b0001 << byte_off;
        end
        F3_SH: begin
          wdata    = {2{store_data[15:0]}};
          be       = 4'b0011 << byte_off;
          misalign = byte_off[0];
        end
        F3_SW:   misalign = (byte_off != 2'b00);
        default: misalign = 1'b1;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
        F3_LBU:  load_data = {24'd0, sel_byte};
        F3_LH: begin
          load_data = {{16{sel_half[15]}}, sel_half};
          misalign  = byte_off[0];
        end
        F3_LHU: begin
          load_data = {16'd0, sel_half};
          misalign  = byte_off[0];
        end
        F3_LW:   misalign = (byte_off != 2'b00);
        default: misalign = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues data-memory requests, stalls upstream
// until the memory answers, and registers results into the E stage.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic [31:0]           PCPlus4D,
  input  logic [4:0]            RdD,
  input  logic [DATA_WIDTH-1:0] MemWriteDataD,
  input  logic [31:0]           ALUResultD,
  input  logic [2:0]            Funct3D,
  output logic                  DMemReq,
  output logic                  DMemWe,
  output logic [31:0]           DMemAddr,
  output logic [DATA_WIDTH-1:0] DMemWData,
  output logic [3:0]            DMemBe,
  input  logic                  DMemReady,
  input  logic [DATA_WIDTH-1:0] DMemRData,
  output logic [31:0]           ForwardALUResultDH,
  output logic [4:0]            RdH,
  output logic                  RegWriteH,
  output logic                  StallM,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic [4:0]            RdE,
  output logic [31:0]           ALUResultE,
  output logic [DATA_WIDTH-1:0] ReadDataE,
  output logic [31:0]           PCPlus4E,
  output logic                  MisalignE
);

  state_t state_q, state_d;
  logic is_load, is_store, mem_op, misalign, legal_access, done;
  logic [31:0] load_data;

  assign is_load      = (ResultSrcD == RES_LOAD);
  assign is_store     = MemWriteD;
  assign mem_op       = is_load | is_store;
  assign legal_access = mem_op & ~misalign;

  assign ForwardALUResultDH = ALUResultD;
  assign RdH                = RdD;
  assign RegWriteH          = RegWriteD;

  assign DMemAddr = {ALUResultD[31:2], 2'b00};
  assign DMemWe   = is_store;

  lsu_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (Funct3D),
    .byte_off   (ALUResultD[1:0]),
    .store_data (MemWriteDataD),
    .rdata      (DMemRData),
    .wdata      (DMemWData),
    .be         (DMemBe),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request and stall are also masked by rst_n so nothing leaks out while held in reset.
  always_comb begin
    state_d = state_q;
    DMemReq = 1'b0;
    StallM  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (legal_access) begin
          DMemReq = 1'b1;
          if (DMemReady) begin
            done = 1'b1;
          end else begin
            StallM  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        DMemReq = 1'b1;
        if (DMemReady) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      DMemReq = 1'b0;
      StallM  = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteE  <= 1'b0;
      ResultSrcE <= 2'b00;
      RdE        <= 5'd0;
      ALUResultE <= 32'd0;
      ReadDataE  <= '0;
      PCPlus4E   <= 32'd0;
      MisalignE  <= 1'b0;
    end else if (StallM) begin
      RegWriteE <= 1'b0;
      MisalignE <= 1'b0;
    end else begin
      RegWriteE  <= RegWriteD & ~is_store & ~(mem_op & misalign);
      ResultSrcE <= ResultSrcD;
      RdE        <= RdD;
      ALUResultE <= ALUResultD;
      PCPlus4E   <= PCPlus4D;
      MisalignE  <= mem_op & misalign;
      ReadDataE  <= (done && is_load) ? load_data : '0;
    end
  end

endmodule
